// File: rtl/trng_harvest_if.sv
// Consumer-side bus of the TRNG harvester: the harvested word, its valid flag
// and the one-cycle read acknowledge.
interface trng_harvest_if;
  logic [31:0] data;
  logic        valid;
  logic        rd_strobe;

  modport master (output data, output valid, input rd_strobe);
  modport slave  (input data, input valid, output rd_strobe);
endinterface

// File: rtl/trng_harvest.sv
// Ring-oscillator entropy harvester: warm up, sample osc_in every SAMPLE_DIV clocks,
// pack 32 bits into a word. Define TRNG_VN_DEBIAS_EN for von Neumann debiasing.
module trng_harvest #(
  parameter int SAMPLE_DIV = 16,
  parameter int WARMUP     = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           osc_in,
  output logic           osc_enable,
  trng_harvest_if.master bus
);

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);

  logic              sync_p0;
  logic              sync_p1;
  logic [1:0]        state;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [31:0]       shift;
  logic [5:0]        bit_cnt;
  logic [31:0]       data_r;
  logic              valid_r;
  logic              sample_tick;
  logic              accept;
  logic              acc_bit;

  assign bus.data  = data_r;
  assign bus.valid = valid_r;

  // Stage p0/p1: metastability guard for the asynchronous oscillator output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= osc_in;
      sync_p1 <= sync_p0;
    end
  end

  // No sampling once 32 bits are in; that cycle is spent transferring the word.
  assign sample_tick = (state == ST_FILL) && (div_cnt == DIV_LAST) && (bit_cnt != 6'd32);

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_have;
  logic pair_first;

  always_comb begin
    accept  = sample_tick && pair_have && (pair_first != sync_p1);
    acc_bit = pair_first;
  end

  // Pair state only lives inside FILL, so any exit drops a half-collected pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
    end else if ((state != ST_FILL) || (bit_cnt == 6'd32)) begin
      pair_have  <= 1'b0;
      pair_first <= 1'b0;
    end else if (sample_tick) begin
      pair_have  <= ~pair_have;
      pair_first <= pair_have ? 1'b0 : sync_p1;
    end
  end
`else
  always_comb begin
    accept  = sample_tick;
    acc_bit = sync_p1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_WARMUP;
      warm_cnt   <= '0;
      div_cnt    <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      osc_enable <= 1'b0;
    end else begin
      case (state)
        ST_WARMUP: begin
          osc_enable <= 1'b1;
          div_cnt    <= '0;
          if (warm_cnt == WARM_LAST) begin
            warm_cnt <= '0;
            state    <= ST_FILL;
          end else begin
            warm_cnt <= warm_cnt + WARM_W'(1);
          end
        end
        ST_FILL: begin
          if (bit_cnt == 6'd32) begin
            data_r     <= shift;
            valid_r    <= 1'b1;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            osc_enable <= 1'b0;
            state      <= ST_FULL;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (accept) begin
              shift   <= {shift[30:0], acc_bit};
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        ST_FULL: begin
          div_cnt    <= '0;
          osc_enable <= 1'b0;
          if (valid_r && bus.rd_strobe) begin
            valid_r    <= 1'b0;
            warm_cnt   <= '0;
            osc_enable <= 1'b1;
            state      <= ST_WARMUP;
          end
        end
        default: begin
          state <= ST_WARMUP;
        end
      endcase
    end
  end

endmodule

// File: doc/trng_harvest.md
TRNG_HARVEST -- requirements
Module: trng_harvest

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 16: clk cycles between osc_in samples (legal range 2..1024).
REQ-002 SHALL have parameter WARMUP, default 64: clk cycles the oscillator runs before the first sample (legal range 1..4096).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port osc_in  input  1  ring-oscillator output; asynchronous to clk.
REQ-006 SHALL have port osc_enable  output  1  oscillator run enable; drives the oscillator's resetq.
REQ-007 SHALL have port rd_strobe  input  1  one-cycle consumer acknowledge of data.
REQ-008 SHALL have port data  output  32  harvested random word.
REQ-009 SHALL have port valid  output  1  data holds an unread complete word.

Function
REQ-010 SHALL pass osc_in through a two-flop synchronizer before any other use.
REQ-011 SHALL implement FSM states WARMUP, FILL, FULL; the reset state is WARMUP.
REQ-012 SHALL drive osc_enable high in WARMUP and FILL and low in FULL; osc_enable is registered.
REQ-013 WARMUP: a counter SHALL count WARMUP cycles with osc_enable high, then move to FILL with the sample divider at 0.
REQ-014 FILL: the divider SHALL wrap at SAMPLE_DIV-1, and one synchronized sample SHALL be taken on each wrap.
REQ-015 Samples SHALL be grouped into non-overlapping pairs (a,b); with debias, a!=b accepts bit a, and a==b discards both samples.
REQ-016 Each accepted bit SHALL enter a 32-bit shift register at the LSB, shifting left; a 6-bit count SHALL track accepted bits.
REQ-017 On the 32nd accepted bit, the next cycle SHALL load data from the shift register, set valid, clear the count, and enter FULL.
REQ-018 FULL: no sampling SHALL occur; the divider and pair state SHALL hold at 0; data is stable.
REQ-019 rd_strobe with valid=1 SHALL clear valid on the next cycle and return the FSM to WARMUP; data keeps its old value.
REQ-020 rd_strobe with valid=0 SHALL be ignored, including in the cycle in which valid is being set.
REQ-021 A partial pair SHALL be discarded whenever the FSM leaves FILL.

Reset
REQ-022 While reset is high, the block SHALL force data=0, valid=0, osc_enable=0, all counters 0, the synchronizer 0 and the state WARMUP.
REQ-023 Reset asserted mid-fill SHALL discard all partially collected bits; after release, the next word starts from bit 0 after a full WARMUP.
REQ-024 osc_enable SHALL go high on the first clk edge after reset deasserts.

Configuration
REQ-025 Macro TRNG_VN_DEBIAS_EN defined: the von Neumann pairing of REQ-015 SHALL apply.
REQ-026 TRNG_VN_DEBIAS_EN undefined: every sample SHALL be accepted as one bit, no pairing logic SHALL be present, and the word takes exactly 32 samples.

Verification (SAMPLE_DIV=16, WARMUP=64)
REQ-027 Reset held 5 cycles with osc_in toggling -> data=0x00000000, valid=0, osc_enable=0 throughout.
REQ-028 Debias on; bench drives samples alternating 0,1 (pairs (0,1)) -> after 32 pairs, data=0x00000000, valid=1, osc_enable=0; with pairs (1,0) -> data=0xFFFFFFFF.
REQ-029 osc_in held 1 -> debias on: valid stays 0 for 20000 cycles; debias off: data=0xFFFFFFFF, valid=1 after 64+32*16 cycles (+-3 cycles).
REQ-030 FULL with data=0xFFFFFFFF, pulse rd_strobe -> valid=0 and osc_enable=1 on the next cycle; with osc_in held 0, the next word is 0x00000000 (debias off).
REQ-031 Reset pulsed after 20 accepted bits, then pairs (1,0) -> the next word is exactly 0xFFFFFFFF (no stale bits); rd_strobe while valid=0 -> no state change.
